clkdiv_multi: RTL and testbench
===============================

Name: clkdiv_multi

Overview:
- Parametrised multi-channel clock divider / tick generator for board-level timing: display scan, debounce, slow CPU single-step clocks.
- Each channel has a run-time programmable divisor and a toggle or pulse output mode.
- Divisor changes are shadowed and applied only at a period boundary, so no output runt pulses occur.
- Sits between the board clock and the slow peripheral logic.

Parameters:
NCH, 4, number of independent channels (>=1)
CNT_W, 32, counter and divisor width in bits
DEF_DIV, 100_000_000, divisor loaded into every channel at reset (>=2, < 2^CNT_W)
CH_W, $clog2(NCH) (min 1), width of channel select; derived, not overridden

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
en  in  NCH  per-channel run enable, sampled on clk
wr_en  in  1  write strobe for the divisor/mode of channel wr_ch
wr_ch  in  CH_W  channel select for write; values >= NCH are ignored
wr_div  in  CNT_W  new divisor D (output period = D clk cycles)
wr_mode  in  1  0 = toggle (square wave), 1 = pulse (1-cycle strobe)
clk_out  out  NCH  divided clock per channel
tick  out  NCH  one-cycle strobe on the last cycle of each period
pending  out  NCH  shadow divisor/mode written but not yet applied

Behaviour:
- The clock and reset are fixed: one clock; reset is asynchronous and active-low. Ports are named clk and rst; rst asserts at 0.
- Per-channel state:
  - active divisor D, active mode M
  - shadow divisor S, shadow mode SM, pending flag P
  - counter cnt[CNT_W-1:0]
  - run flag R
- Reset (rst=0, asynchronous):
  - cnt=0, R=0
  - D=S=DEF_DIV, M=SM=0, P=0
  - clk_out=0, tick=0, pending=0
- Outputs depend only on registers; there is no combinational path from any input to any output.
- Run control, on each edge:
  - If en[i]=0: R<=0, cnt<=0.
  - If en[i]=1: R<=1. If R=1, cnt<=(cnt==D-1)?0:cnt+1; if R=0, cnt stays 0.
- Start latency: en rises before edge t. After edge t, R=1 and cnt=0. The first increment happens at edge t+1.
- Toggle mode (M=0):
  - clk_out[i]=1 iff R=1 and cnt < (D>>1), so high for D>>1 cycles and low for D-(D>>1) cycles.
  - D=4 gives 2/2. D=3 gives 1 high / 2 low. D=2 gives 1/1.
- Pulse mode (M=1): clk_out[i]=tick[i].
- tick[i]=1 iff R=1 and cnt==D-1, in both modes.
- Write handling (wr_en=1, wr_ch<NCH):
  - wr_div<2 is clamped to 2.
  - On the write edge: S<=value, SM<=wr_mode, P<=1.
- Apply rules:
  - A wrap edge is an edge with R=1, en=1 and cnt==D-1. At a wrap edge with P=1: D<=S, M<=SM, P<=0.
  - At an edge where en=0, or R=0, with P=1: the write is applied immediately.
  - Write on the same edge as a wrap or idle edge for that channel: the written value bypasses the shadow and goes straight to D/M, and P stays 0.
  - Several writes before a boundary: the last write wins.
- Channels are fully independent. A write to one channel never disturbs another.
- Boundary cases:
  - D=2^CNT_W-1 must count without overflow.
  - en dropped mid-period: the output goes low on the next cycle and the partial period is discarded.
  - rst mid-operation: everything returns to reset values immediately. The write in flight is lost.
- The design holds no state beyond that listed above. Target size is roughly 150-250 lines.

Test Plan:
- Reset check: NCH=4, DEF_DIV=10, release rst, en=4'b0001. Channel 0: 10-cycle period, 5 high / 5 low. tick on every 10th cycle, aligned with the last low cycle. Channels 1-3: clk_out=0, tick=0.
- Odd divisor and clamp: write D=3 to channel 1 while it is idle, then en[1]=1. Expect 1 high / 2 low repeating. Write D=0 → behaves as D=2 (1/1), pending never asserted.
- Shadowed update: channel 0 running D=10, write D=4 at cnt=3. pending[0]=1 until the wrap edge. The current 10-cycle period completes intact, then 4-cycle periods follow with no runt pulse.
- Same-edge write at wrap: write D=6 exactly on the edge where cnt==9. The next period is 6 cycles and pending stays 0.
- Pulse mode and independence: write channel 2 with mode=1, D=5. clk_out[2] is a 1-cycle pulse every 5 cycles. Channel 0's waveform is unchanged, cycle-exact against the model.
- Async reset mid-period: pull rst low between clk edges while channels run. Outputs clear with no clock edge. On release with en held high, each channel restarts at cnt=0 with D=DEF_DIV.

Source files
------------

// File: rtl/clkdiv_multi_if.sv
// clkdiv_multi_if: control/status bundle for the multi-channel clock divider.
//   en       per-channel run enable
//   wr_en    divisor/mode write strobe for channel wr_ch
//   wr_ch    channel select (values >= NCH match no channel)
//   wr_div   new divisor (period in clk cycles, < 2 clamps to 2)
//   wr_mode  0 = toggle (square wave), 1 = pulse (one-cycle strobe)
//   clk_out  divided clock per channel
//   tick     one-cycle strobe on the last cycle of each period
//   pending  shadow divisor/mode written but not yet applied
// master = the controlling side, slave = the divider.
interface clkdiv_multi_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   en;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic             wr_mode;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pending;

    modport master (output en, wr_en, wr_ch, wr_div, wr_mode,
                    input  clk_out, tick, pending);
    modport slave  (input  en, wr_en, wr_ch, wr_div, wr_mode,
                    output clk_out, tick, pending);
endinterface

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent programmable clock dividers / tick generators.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  clkdiv_multi_if.slave (enables, divisor writes, per-channel outputs)
// Each channel runs a counter over 0..D-1. Divisor/mode writes are held in a
// shadow register and only take effect at a period boundary (wrap or idle)
// so a running output never shows a shortened period.

// One divider channel.
//   en       run enable
//   wr_hit   a (clamped) write for this channel is present this cycle
//   wr_val   clamped divisor, wr_mode new mode
//   clk_out/tick/pending as in the interface
module clkdiv_lane #(
    parameter int              CNT_W   = 32,
    parameter longint unsigned DEF_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_val,
    input  logic             wr_mode,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt, div, sdiv;
    logic             run, mode, smode, pend;
    logic             last, boundary;

    assign last     = (cnt == div - 1'b1);
    // Idle edges (not running, or being stopped) count as boundaries too:
    // nothing visible can be cut short there.
    assign boundary = !en || !run || last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            run   <= 1'b0;
            div   <= RST_DIV;
            sdiv  <= RST_DIV;
            mode  <= 1'b0;
            smode <= 1'b0;
            pend  <= 1'b0;
        end else begin
            if (!en) begin
                run <= 1'b0;
                cnt <= '0;
            end else begin
                run <= 1'b1;
                // First edge after enable only sets run; counting starts next edge.
                if (run) cnt <= last ? '0 : cnt + 1'b1;
            end

            if (boundary) begin
                if (wr_hit) begin
                    // Write coincides with a boundary: apply directly.
                    div   <= wr_val;
                    mode  <= wr_mode;
                    sdiv  <= wr_val;
                    smode <= wr_mode;
                    pend  <= 1'b0;
                end else if (pend) begin
                    div  <= sdiv;
                    mode <= smode;
                    pend <= 1'b0;
                end
            end else if (wr_hit) begin
                sdiv  <= wr_val;
                smode <= wr_mode;
                pend  <= 1'b1;
            end
        end
    end

    // Outputs decode registered state only.
    assign tick    = run && last;
    assign clk_out = mode ? tick : (run && (cnt < (div >> 1)));
    assign pending = pend;
endmodule

module clkdiv_multi #(
    parameter int              NCH     = 4,
    parameter int              CNT_W   = 32,
    parameter longint unsigned DEF_DIV = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    clkdiv_multi_if.slave        bus
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CNT_W-1:0] wr_val;

    // Divisors below 2 cannot form a period with both a high and a low phase.
    assign wr_val = (bus.wr_div < CNT_W'(2)) ? CNT_W'(2) : bus.wr_div;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        clkdiv_lane #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en[i]),
            .wr_hit  (bus.wr_en && (bus.wr_ch == CH_W'(i))),
            .wr_val  (wr_val),
            .wr_mode (bus.wr_mode),
            .clk_out (bus.clk_out[i]),
            .tick    (bus.tick[i]),
            .pending (bus.pending[i])
        );
    end
endmodule

// File: tb/tb_clkdiv_multi.sv
module tb_clkdiv_multi;
    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int DEFD  = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    clkdiv_multi_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    clkdiv_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEFD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: each channel is "where am I in the current period",
    // the period length in force, and any queued (divisor, mode) update.
    bit     m_run  [NCH];
    longint m_pos  [NCH];
    longint m_per  [NCH];
    bit     m_pulse[NCH];
    longint m_qper [NCH];
    bit     m_qpul [NCH];
    bit     m_queued[NCH];
    logic [NCH-1:0] e_clk, e_tick, e_pend;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_per[i] = DEFD; m_pulse[i] = 0;
            m_qper[i] = DEFD; m_qpul[i] = 0; m_queued[i] = 0;
        end
        e_clk = '0; e_tick = '0; e_pend = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            bit     hit = bus.wr_en && (int'(bus.wr_ch) == i);
            longint val = (bus.wr_div < 2) ? 2 : longint'(bus.wr_div);
            bit     at_end = m_run[i] && (m_pos[i] == m_per[i] - 1);
            bit     safe = !bus.en[i] || !m_run[i] || at_end;
            if (!bus.en[i]) begin
                m_run[i] = 0; m_pos[i] = 0;
            end else begin
                if (m_run[i]) m_pos[i] = (m_pos[i] + 1) % m_per[i];
                m_run[i] = 1;
            end
            if (safe) begin
                if (hit) begin
                    m_per[i] = val; m_pulse[i] = bus.wr_mode; m_queued[i] = 0;
                end else if (m_queued[i]) begin
                    m_per[i] = m_qper[i]; m_pulse[i] = m_qpul[i]; m_queued[i] = 0;
                end
            end else if (hit) begin
                m_qper[i] = val; m_qpul[i] = bus.wr_mode; m_queued[i] = 1;
            end
            e_tick[i] = m_run[i] && (m_pos[i] == m_per[i] - 1);
            e_clk[i]  = m_pulse[i] ? e_tick[i] : (m_run[i] && (m_pos[i] < m_per[i] / 2));
            e_pend[i] = m_queued[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int hi = 0, tk = 0;
        bus.en = '0; bus.wr_en = 0; bus.wr_ch = '0; bus.wr_div = '0; bus.wr_mode = 0;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.clk_out, bus.tick, bus.pending} !== 12'h000) begin
            failures++;
            $display("FAIL reset_vals: got %b want 0", {bus.clk_out, bus.tick, bus.pending});
        end
        model_reset();
        rst = 1;
        bus.en = 4'b0001;
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e_clk, e_tick, e_pend}) begin
                failures++;
                $display("FAIL reset_run k=%0d: got %b want %b", k,
                         {bus.clk_out, bus.tick, bus.pending}, {e_clk, e_tick, e_pend});
            end
            if (k < 20) begin hi += bus.clk_out[0]; tk += bus.tick[0]; end
        end
        checks++;
        if (hi != 10 || tk != 2) begin
            failures++;
            $display("FAIL reset_duty: high=%0d ticks=%0d want 10/2", hi, tk);
        end
    endtask

    task automatic test_odd_clamp();
        int hi = 0;
        bus.wr_en = 1; bus.wr_ch = 2'd1; bus.wr_div = 8'd3; bus.wr_mode = 0;
        step();
        bus.wr_en = 0;
        bus.en[1] = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e_clk, e_tick, e_pend}) begin
                failures++;
                $display("FAIL odd_div k=%0d: got %b want %b", k,
                         {bus.clk_out, bus.tick, bus.pending}, {e_clk, e_tick, e_pend});
            end
            hi += bus.clk_out[1];
        end
        checks++;
        if (hi != 2) begin failures++; $display("FAIL odd_duty: high=%0d want 2", hi); end
        bus.en[1] = 0;
        step();
        bus.wr_en = 1; bus.wr_ch = 2'd1; bus.wr_div = 8'd0;
        step();
        bus.wr_en = 0;
        checks++;
        if (bus.pending[1] !== 1'b0) begin
            failures++; $display("FAIL clamp_pend: got %b want 0", bus.pending[1]);
        end
        bus.en[1] = 1;
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e_clk, e_tick, e_pend}) begin
                failures++;
                $display("FAIL clamp k=%0d: got %b want %b", k,
                         {bus.clk_out, bus.tick, bus.pending}, {e_clk, e_tick, e_pend});
            end
            hi += bus.clk_out[1];
        end
        checks++;
        if (hi != 4) begin failures++; $display("FAIL clamp_duty: high=%0d want 4", hi); end
    endtask

    task automatic test_shadow();
        int n = 0, pc = 0, hi = 0;
        while (m_pos[0] != 3 && n < 40) begin step(); n++; end
        checks++;
        if (n >= 40) begin failures++; $display("FAIL shadow_wait: timeout got %0d want <40", n); end
        bus.wr_en = 1; bus.wr_ch = 2'd0; bus.wr_div = 8'd4; bus.wr_mode = 0;
        step();
        bus.wr_en = 0;
        checks++;
        if (bus.pending[0] !== 1'b1) begin
            failures++; $display("FAIL shadow_pend: got %b want 1", bus.pending[0]);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e_clk, e_tick, e_pend}) begin
                failures++;
                $display("FAIL shadow k=%0d: got %b want %b", k,
                         {bus.clk_out, bus.tick, bus.pending}, {e_clk, e_tick, e_pend});
            end
            if (k < 12) pc += bus.pending[0];
            else hi += bus.clk_out[0];
        end
        checks++;
        if (pc != 5 || hi != 4) begin
            failures++; $display("FAIL shadow_timing: pend=%0d high=%0d want 5/4", pc, hi);
        end
    endtask

    task automatic test_same_edge_wrap();
        int n = 0, first = 0, second = 0;
        bus.en[0] = 0;
        step();
        bus.wr_en = 1; bus.wr_ch = 2'd0; bus.wr_div = 8'd10; bus.wr_mode = 0;
        step();
        bus.wr_en = 0;
        bus.en[0] = 1;
        while (m_pos[0] != 9 && n < 40) begin step(); n++; end
        checks++;
        if (n >= 40) begin failures++; $display("FAIL wrap_wait: timeout got %0d want <40", n); end
        bus.wr_en = 1; bus.wr_ch = 2'd0; bus.wr_div = 8'd6; bus.wr_mode = 0;
        step();
        bus.wr_en = 0;
        checks++;
        if (bus.pending[0] !== 1'b0) begin
            failures++; $display("FAIL wrap_pend: got %b want 0", bus.pending[0]);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e_clk, e_tick, e_pend}) begin
                failures++;
                $display("FAIL wrap k=%0d: got %b want %b", k,
                         {bus.clk_out, bus.tick, bus.pending}, {e_clk, e_tick, e_pend});
            end
            if (bus.tick[0] && first == 0) first = k;
            else if (bus.tick[0] && second == 0) second = k;
        end
        checks++;
        if (first != 5 || second != 11) begin
            failures++; $display("FAIL wrap_period: ticks at %0d,%0d want 5,11", first, second);
        end
    endtask

    task automatic test_pulse_indep();
        int pulses = 0;
        bus.wr_en = 1; bus.wr_ch = 2'd2; bus.wr_div = 8'd5; bus.wr_mode = 1;
        step();
        bus.wr_en = 0; bus.wr_mode = 0;
        bus.en[2] = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e_clk, e_tick, e_pend}) begin
                failures++;
                $display("FAIL pulse k=%0d: got %b want %b", k,
                         {bus.clk_out, bus.tick, bus.pending}, {e_clk, e_tick, e_pend});
            end
            pulses += bus.clk_out[2];
        end
        checks++;
        if (pulses != 4) begin failures++; $display("FAIL pulse_count: got %0d want 4", pulses); end
    endtask

    task automatic test_async_reset();
        bus.en = 4'b1111;
        repeat (7) step();
        #2;
        bus.wr_en = 1; bus.wr_ch = 2'd3; bus.wr_div = 8'd7;
        #1 rst = 0;
        #1;
        checks++;
        if ({bus.clk_out, bus.tick, bus.pending} !== 12'h000) begin
            failures++;
            $display("FAIL async_clear: got %b want 0", {bus.clk_out, bus.tick, bus.pending});
        end
        model_reset();
        bus.wr_en = 0;
        #2 rst = 1;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e_clk, e_tick, e_pend}) begin
                failures++;
                $display("FAIL async_restart k=%0d: got %b want %b", k,
                         {bus.clk_out, bus.tick, bus.pending}, {e_clk, e_tick, e_pend});
            end
            if (k == 9) begin
                checks++;
                if (bus.tick !== 4'b1111) begin
                    failures++; $display("FAIL async_period: tick=%b want 1111", bus.tick);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 39) == 0) bus.en[i] = ~bus.en[i];
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_ch   = 2'($urandom_range(0, NCH - 1));
            bus.wr_div  = 8'($urandom_range(0, 12));
            bus.wr_mode = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e_clk, e_tick, e_pend}) begin
                failures++;
                $display("FAIL random k=%0d: got %b want %b", k,
                         {bus.clk_out, bus.tick, bus.pending}, {e_clk, e_tick, e_pend});
            end
        end
        bus.wr_en = 0;
    endtask

    task automatic test_max_div();
        int ticks = 0, hi = 0;
        bus.en[3] = 0;
        step();
        bus.wr_en = 1; bus.wr_ch = 2'd3; bus.wr_div = 8'd255; bus.wr_mode = 0;
        step();
        bus.wr_en = 0;
        bus.en[3] = 1;
        for (int k = 0; k < 520; k++) begin
            step();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e_clk, e_tick, e_pend}) begin
                failures++;
                $display("FAIL maxdiv k=%0d: got %b want %b", k,
                         {bus.clk_out, bus.tick, bus.pending}, {e_clk, e_tick, e_pend});
            end
            ticks += bus.tick[3];
            if (k < 255) hi += bus.clk_out[3];
        end
        checks++;
        if (ticks != 2 || hi != 127) begin
            failures++; $display("FAIL maxdiv_shape: ticks=%0d high=%0d want 2/127", ticks, hi);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_odd_clamp();
        test_shadow();
        test_same_edge_wrap();
        test_pulse_indep();
        test_async_reset();
        test_random();
        test_max_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
